// File: rtl/sys_uart_pkg.sv
// rtl/sys_uart_pkg.sv - shared constants, register offsets and FSM state types for sys_uart
package sys_uart_pkg;
    localparam logic [31:0] UART_BASE    = 32'h3000_0000;
    localparam logic [1:0]  UART_CTRL    = 2'd0;
    localparam logic [1:0]  UART_STATUS  = 2'd1;
    localparam logic [1:0]  UART_BAUD    = 2'd2;
    localparam logic [1:0]  UART_DATA    = 2'd3;
    localparam logic [15:0] UART_MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < UART_MIN_DIV) ? UART_MIN_DIV : d;
    endfunction
endpackage

// File: rtl/sys_uart_if.sv
// rtl/sys_uart_if.sv - simplified AXI4-lite slave channel of the crossbar (no prot/resp)
interface sys_uart_if;
    logic [31:0] uart_axi_awaddr;
    logic        uart_axi_awvalid;
    logic        uart_axi_awready;
    logic [31:0] uart_axi_wdata;
    logic [3:0]  uart_axi_wstrb;
    logic        uart_axi_wvalid;
    logic        uart_axi_wready;
    logic [31:0] uart_axi_araddr;
    logic        uart_axi_arvalid;
    logic        uart_axi_arready;
    logic [31:0] uart_axi_rdata;
    logic        uart_axi_rvalid;
    logic        uart_axi_rready;

    modport master (
        output uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
               uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
        input  uart_axi_awready, uart_axi_wready, uart_axi_arready, uart_axi_rdata, uart_axi_rvalid
    );
    modport slave (
        input  uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
               uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
        output uart_axi_awready, uart_axi_wready, uart_axi_arready, uart_axi_rdata, uart_axi_rvalid
    );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - receive path: 2-flop synchroniser, RX FSM and mid-bit sampler
module uart_rx_core
    import sys_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        en,
    input  logic [15:0] div,
    output logic [7:0]  data,
    output logic        done,
    output logic        frame_err
);
    logic        rx_s1, rx_s2, rx_prev;
    rx_state_t   state, state_d;
    logic [15:0] cnt, bit_div;
    logic [2:0]  bit_idx;
    logic        tick;

    assign tick = (cnt == bit_div - 16'd1);

    always_comb begin
        state_d = state;
        case (state)
            RX_IDLE:  if (en && rx_prev && !rx_s2) state_d = RX_START;
            RX_START: if (tick) state_d = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_div   <= '0;
            bit_idx   <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            state     <= state_d;
            done      <= 1'b0;
            frame_err <= 1'b0;
            // The first wait is half a bit so every later sample lands mid-bit.
            if (state == RX_IDLE) begin
                cnt     <= '0;
                bit_div <= {1'b0, div[15:1]};
            end else if (tick) begin
                cnt     <= '0;
                bit_div <= div;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && tick) begin
                data    <= {rx_s2, data[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == RX_STOP && tick) begin
                done      <= rx_s2;
                frame_err <= ~rx_s2;
            end
        end
    end
endmodule

// File: rtl/sys_uart.sv
// rtl/sys_uart.sv - memory-mapped 8N1 UART: register file, bus handshake and transmitter
module sys_uart
    import sys_uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic      clk,
    input  logic      rst_n,
    sys_uart_if.slave bus,
    output logic      uart_tx,
    input  logic      uart_rx,
    output logic      uart_irq
);
    logic        tx_en, rx_en, rx_ie;
    logic        rx_valid, rx_overrun, frame_err;
    logic [15:0] baud, baud_wr;
    logic [7:0]  rx_byte, core_byte;
    logic        core_done, core_ferr;
    logic        rvalid_q;
    logic [31:0] rdata_q, rd_word;
    logic        wr_hs, rd_hs, rd_data_clr, tx_go, tx_busy;
    logic [1:0]  wr_sel, rd_sel;

    tx_state_t   tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit, tx_bit_d;
    logic [7:0]  tx_shift;
    logic        tx_tick, tx_line_d;

    wire unused_bus_bits = ^{bus.uart_axi_awaddr[31:4], bus.uart_axi_awaddr[1:0],
                             bus.uart_axi_araddr[31:4], bus.uart_axi_araddr[1:0],
                             bus.uart_axi_wdata[31:16], bus.uart_axi_wstrb[3:2]};

    assign wr_hs                = bus.uart_axi_awvalid & bus.uart_axi_wvalid;
    assign rd_hs                = bus.uart_axi_arvalid & ~rvalid_q;
    assign bus.uart_axi_awready = wr_hs;
    assign bus.uart_axi_wready  = wr_hs;
    assign bus.uart_axi_arready = rd_hs;
    assign bus.uart_axi_rvalid  = rvalid_q;
    assign bus.uart_axi_rdata   = rdata_q;
    assign wr_sel      = bus.uart_axi_awaddr[3:2];
    assign rd_sel      = bus.uart_axi_araddr[3:2];
    assign rd_data_clr = rd_hs && (rd_sel == UART_DATA);
    assign tx_busy     = (tx_state != TX_IDLE);
    assign tx_go       = wr_hs && (wr_sel == UART_DATA) && bus.uart_axi_wstrb[0] && tx_en && !tx_busy;
    assign uart_irq    = rx_valid & rx_ie;
    assign baud_wr     = {bus.uart_axi_wstrb[1] ? bus.uart_axi_wdata[15:8] : baud[15:8],
                          bus.uart_axi_wstrb[0] ? bus.uart_axi_wdata[7:0]  : baud[7:0]};

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            UART_CTRL:   rd_word[2:0]  = {rx_ie, rx_en, tx_en};
            UART_STATUS: rd_word[3:0]  = {frame_err, rx_overrun, rx_valid, tx_busy};
            UART_BAUD:   rd_word[15:0] = baud;
            default:     rd_word[7:0]  = rx_byte;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_ie, rx_en, tx_en} <= '0;
            baud       <= BAUD_DIV_RST;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_hs && bus.uart_axi_wstrb[0] && wr_sel == UART_CTRL)
                {rx_ie, rx_en, tx_en} <= bus.uart_axi_wdata[2:0];
            if (wr_hs && bus.uart_axi_wstrb[0] && wr_sel == UART_STATUS) begin
                if (bus.uart_axi_wdata[2]) rx_overrun <= 1'b0;
                if (bus.uart_axi_wdata[3]) frame_err  <= 1'b0;
            end
            if (wr_hs && wr_sel == UART_BAUD && |bus.uart_axi_wstrb[1:0])
                baud <= clamp_div(baud_wr);
            // A completion that coincides with a DATA read refills rather than overruns.
            if (core_done) begin
                if (rx_valid && !rd_data_clr) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_byte  <= core_byte;
                    rx_valid <= 1'b1;
                end
            end else if (rd_data_clr) begin
                rx_valid <= 1'b0;
            end
            if (core_ferr) frame_err <= 1'b1;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && bus.uart_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign tx_tick = (tx_cnt == tx_div - 16'd1);

    always_comb begin
        tx_state_d = tx_state;
        tx_bit_d   = tx_bit;
        case (tx_state)
            TX_IDLE:  if (tx_go) tx_state_d = TX_START;
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
            end
            TX_DATA:  if (tx_tick) begin
                if (tx_bit == 3'd7) tx_state_d = TX_STOP;
                else                tx_bit_d   = tx_bit + 3'd1;
            end
            TX_STOP:  if (tx_tick) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        tx_line_d = 1'b1;
        if (tx_state_d == TX_START)     tx_line_d = 1'b0;
        else if (tx_state_d == TX_DATA) tx_line_d = tx_shift[tx_bit_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_div   <= BAUD_DIV_RST;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_bit   <= tx_bit_d;
            uart_tx  <= tx_line_d;
            if (tx_go) tx_shift <= bus.uart_axi_wdata[7:0];
            // The divisor is re-latched at every bit boundary so BAUD writes land cleanly.
            if (tx_state_d != tx_state || tx_tick) begin
                tx_cnt <= '0;
                tx_div <= baud;
            end else if (tx_busy) begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    uart_rx_core u_rx_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .en        (rx_en),
        .div       (baud),
        .data      (core_byte),
        .done      (core_done),
        .frame_err (core_ferr)
    );
endmodule
